dp_tcdm_port_scheduler: RTL and testbench

Time-multiplexing scheduler for one dot-product unit's shared TCDM read port, where the matrix source and the vector source reach memory through a static two-way mux. The block owns the mux select: it grants the port to one source for a bounded burst and drains outstanding reads before flipping the select. It gates new requests during the switch. One instance per dot-product unit sits beside the streamer and replaces the software-driven select field.

---
 rtl/dp_tcdm_port_scheduler.sv | 136 +++++++++++++
 tb/tb_dp_tcdm_port_scheduler.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/dp_tcdm_port_scheduler.sv
// Shared TCDM read-port scheduler for one dot-product unit: owns the matrix/vector mux select,
// bounds each ownership burst and drains outstanding reads before flipping the select.
module dp_tcdm_port_scheduler #(
    parameter int OUTST_W = 4
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               clear_i,
    input  logic               enable_i,
    input  logic [7:0]         burst_len_i,
    input  logic               mat_req_i,
    input  logic               vec_req_i,
    input  logic               port_req_i,
    input  logic               port_gnt_i,
    input  logic               port_r_valid_i,
    output logic               sel_o,
    output logic               gate_o,
    output logic               switch_o,
    output logic [OUTST_W-1:0] outstanding_o,
    output logic               err_o
);

    typedef enum logic [1:0] {
        MAT_OWN   = 2'd0,
        MAT_DRAIN = 2'd1,
        VEC_OWN   = 2'd2,
        VEC_DRAIN = 2'd3
    } state_e;

    state_e             state_q;
    logic [7:0]         grant_cnt_q;
    logic [OUTST_W-1:0] outst_q;
    logic               sel_q;
    logic               switch_q;
    logic               err_q;

    logic               beat;
    logic               is_drain;
    logic               cur_req;
    logic               oth_req;
    logic [8:0]         grant_cnt_d;
    logic [8:0]         burst_eff;
    logic               release_own;
    logic               outst_empty;
    logic               outst_full;
    logic               outst_inc;
    logic               outst_dec;
    logic               err_set;

    // Grant counter only matters relative to an 8-bit burst length, so it sticks at the top.
    function automatic logic [7:0] sat_grant_cnt(input logic [8:0] cnt);
        return cnt[8] ? 8'hFF : cnt[7:0];
    endfunction

    function automatic logic [OUTST_W-1:0] outst_next(input logic [OUTST_W-1:0] cnt,
                                                      input logic inc, input logic dec);
        logic [OUTST_W-1:0] nxt;
        nxt = cnt;
        if (inc && !dec) nxt = cnt + 1'b1;
        if (dec && !inc) nxt = cnt - 1'b1;
        return nxt;
    endfunction

    assign beat        = port_req_i & port_gnt_i;
    assign is_drain    = (state_q == MAT_DRAIN) || (state_q == VEC_DRAIN);
    assign cur_req     = sel_q ? vec_req_i : mat_req_i;
    assign oth_req     = sel_q ? mat_req_i : vec_req_i;
    assign grant_cnt_d = {1'b0, grant_cnt_q} + {8'd0, beat};
    assign burst_eff   = (burst_len_i == 8'd0) ? 9'd1 : {1'b0, burst_len_i};
    assign release_own = oth_req & (~cur_req | (grant_cnt_d >= burst_eff));

    // A beat at saturation is absorbed only if a response retires one in the same cycle.
    assign outst_empty = (outst_q == '0);
    assign outst_full  = &outst_q;
    assign outst_dec   = port_r_valid_i & ~outst_empty;
    assign outst_inc   = beat & ~(outst_full & ~outst_dec);
    assign err_set     = (port_r_valid_i & outst_empty) | (beat & outst_full & ~outst_dec);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= MAT_OWN;
            grant_cnt_q <= 8'd0;
            outst_q     <= '0;
            sel_q       <= 1'b0;
            switch_q    <= 1'b0;
            err_q       <= 1'b0;
        end else if (clear_i) begin
            state_q     <= MAT_OWN;
            grant_cnt_q <= 8'd0;
            outst_q     <= '0;
            sel_q       <= 1'b0;
            switch_q    <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            outst_q  <= outst_next(outst_q, outst_inc, outst_dec);
            switch_q <= 1'b0;
            if (err_set) err_q <= 1'b1;
            if (enable_i) begin
                case (state_q)
                    MAT_OWN: begin
                        grant_cnt_q <= sat_grant_cnt(grant_cnt_d);
                        if (release_own) state_q <= MAT_DRAIN;
                    end
                    VEC_OWN: begin
                        grant_cnt_q <= sat_grant_cnt(grant_cnt_d);
                        if (release_own) state_q <= VEC_DRAIN;
                    end
                    MAT_DRAIN: begin
                        if (outst_empty) begin
                            state_q     <= VEC_OWN;
                            sel_q       <= 1'b1;
                            switch_q    <= 1'b1;
                            grant_cnt_q <= 8'd0;
                        end
                    end
                    VEC_DRAIN: begin
                        if (outst_empty) begin
                            state_q     <= MAT_OWN;
                            sel_q       <= 1'b0;
                            switch_q    <= 1'b1;
                            grant_cnt_q <= 8'd0;
                        end
                    end
                    default: state_q <= MAT_OWN;
                endcase
            end
        end
    end

    assign sel_o         = sel_q;
    assign gate_o        = is_drain | ~enable_i;
    assign switch_o      = switch_q;
    assign outstanding_o = outst_q;
    assign err_o         = err_q;

endmodule

// File: tb/tb_dp_tcdm_port_scheduler.sv
// Directed bench for dp_tcdm_port_scheduler: models the wrapper mux/gate and scores each cycle.
module tb_dp_tcdm_port_scheduler;

    logic       clk;
    logic       rst_n;
    logic       clear;
    logic       enable;
    logic [7:0] burst_len;
    logic       mat_req;
    logic       vec_req;
    logic       port_req;
    logic       gnt;
    logic       r_valid;
    logic       sel;
    logic       gate;
    logic       sw;
    logic [3:0] outst;
    logic       err;

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    typedef struct {
        string      tag;
        logic       sel;
        logic       gate;
        logic       sw;
        logic [3:0] outst;
        logic       err;
    } exp_t;

    exp_t sb[$];

    dp_tcdm_port_scheduler #(.OUTST_W(4)) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .clear_i       (clear),
        .enable_i      (enable),
        .burst_len_i   (burst_len),
        .mat_req_i     (mat_req),
        .vec_req_i     (vec_req),
        .port_req_i    (port_req),
        .port_gnt_i    (gnt),
        .port_r_valid_i(r_valid),
        .sel_o         (sel),
        .gate_o        (gate),
        .switch_o      (sw),
        .outstanding_o (outst),
        .err_o         (err)
    );

    // Wrapper behaviour: static mux on sel, request forced low while gated.
    assign port_req = ~gate & (sel ? vec_req : mat_req);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs, check the beat seen this cycle, then check outputs after the edge.
    task automatic step(input string tag, input logic m, input logic v, input logic g,
                        input logic rv, input logic en, input logic clr, input logic e_beat,
                        input logic e_sel, input logic e_gate, input logic e_sw,
                        input int e_out, input logic e_err);
        exp_t e;
        mat_req = m;
        vec_req = v;
        gnt     = g;
        r_valid = rv;
        enable  = en;
        clear   = clr;
        e.tag   = tag;
        e.sel   = e_sel;
        e.gate  = e_gate;
        e.sw    = e_sw;
        e.outst = 4'(e_out);
        e.err   = e_err;
        sb.push_back(e);
        #1;
        chk({tag, ".beat"}, {7'd0, port_req & gnt}, {7'd0, e_beat});
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk({e.tag, ".sel"},   {7'd0, sel},   {7'd0, e.sel});
        chk({e.tag, ".gate"},  {7'd0, gate},  {7'd0, e.gate});
        chk({e.tag, ".sw"},    {7'd0, sw},    {7'd0, e.sw});
        chk({e.tag, ".outst"}, {4'd0, outst}, {4'd0, e.outst});
        chk({e.tag, ".err"},   {7'd0, err},   {7'd0, e.err});
    endtask

    initial begin
        rst_n     = 1'b0;
        clear     = 1'b0;
        enable    = 1'b1;
        burst_len = 8'd4;
        mat_req   = 1'b0;
        vec_req   = 1'b0;
        gnt       = 1'b0;
        r_valid   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst.sel",   {7'd0, sel},   8'd0);
        chk("rst.gate",  {7'd0, gate},  8'd0);
        chk("rst.sw",    {7'd0, sw},    8'd0);
        chk("rst.outst", {4'd0, outst}, 8'd0);
        chk("rst.err",   {7'd0, err},   8'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Disable freezes the FSM and forces the gate.
        step("dis0",     0, 0, 0, 0, 0, 0,  0,  0, 1, 0, 0, 0);
        step("dis_hold", 0, 1, 0, 0, 0, 0,  0,  0, 1, 0, 0, 0);
        step("en_back",  0, 0, 0, 0, 1, 0,  0,  0, 0, 0, 0, 0);

        // Full burst of 4 each way, response one cycle after each grant.
        step("fb_t0",  1, 1, 1, 0, 1, 0,  1,  0, 0, 0, 1, 0);
        step("fb_t1",  1, 1, 1, 1, 1, 0,  1,  0, 0, 0, 1, 0);
        step("fb_t2",  1, 1, 1, 1, 1, 0,  1,  0, 0, 0, 1, 0);
        step("fb_t3",  1, 1, 1, 1, 1, 0,  1,  0, 1, 0, 1, 0);
        step("fb_t4",  1, 1, 1, 1, 1, 0,  0,  0, 1, 0, 0, 0);
        step("fb_t5",  1, 1, 1, 0, 1, 0,  0,  1, 0, 1, 0, 0);
        step("fb_t6",  1, 1, 1, 0, 1, 0,  1,  1, 0, 0, 1, 0);
        step("fb_t7",  1, 1, 1, 1, 1, 0,  1,  1, 0, 0, 1, 0);
        step("fb_t8",  1, 1, 1, 1, 1, 0,  1,  1, 0, 0, 1, 0);
        step("fb_t9",  1, 1, 1, 1, 1, 0,  1,  1, 1, 0, 1, 0);
        step("fb_t10", 1, 1, 1, 1, 1, 0,  0,  1, 1, 0, 0, 0);
        step("fb_t11", 1, 1, 1, 0, 1, 0,  0,  0, 0, 1, 0, 0);

        // Early release: matrix drops its request after two beats.
        step("er0", 1, 1, 1, 0, 1, 0,  1,  0, 0, 0, 1, 0);
        step("er1", 1, 1, 1, 1, 1, 0,  1,  0, 0, 0, 1, 0);
        step("er2", 0, 1, 1, 1, 1, 0,  0,  0, 1, 0, 0, 0);
        step("er3", 0, 1, 1, 0, 1, 0,  0,  1, 0, 1, 0, 0);

        // No contention: vector keeps the port for 20 beats despite burst_len 4.
        step("nc0", 0, 1, 1, 0, 1, 0,  1,  1, 0, 0, 1, 0);
        for (int i = 1; i < 20; i++)
            step($sformatf("nc%0d", i), 0, 1, 1, 1, 1, 0,  1,  1, 0, 0, 1, 0);
        step("nc_end", 0, 0, 1, 1, 1, 0,  0,  1, 0, 0, 0, 0);

        // 20 beats already counted in this ownership, so a matrix request releases at once.
        step("stale0", 1, 1, 0, 0, 1, 0,  0,  1, 1, 0, 0, 0);
        step("stale1", 1, 1, 0, 0, 1, 0,  0,  0, 0, 1, 0, 0);

        // Grant held low: nothing counted, no early switch.
        for (int i = 0; i < 10; i++)
            step($sformatf("nognt%0d", i), 1, 1, 0, 0, 1, 0,  0,  0, 0, 0, 0, 0);

        // Three grants, switch request, responses arrive late.
        step("late_g0", 1, 1, 1, 0, 1, 0,  1,  0, 0, 0, 1, 0);
        step("late_g1", 1, 1, 1, 0, 1, 0,  1,  0, 0, 0, 2, 0);
        step("late_g2", 1, 1, 1, 0, 1, 0,  1,  0, 0, 0, 3, 0);
        step("late_sw", 0, 1, 1, 0, 1, 0,  0,  0, 1, 0, 3, 0);
        for (int i = 0; i < 3; i++)
            step($sformatf("late_wait%0d", i), 0, 1, 1, 0, 1, 0,  0,  0, 1, 0, 3, 0);
        step("late_r2", 0, 1, 1, 1, 1, 0,  0,  0, 1, 0, 2, 0);
        step("late_r1", 0, 1, 1, 1, 1, 0,  0,  0, 1, 0, 1, 0);
        step("late_r0", 0, 1, 1, 1, 1, 0,  0,  0, 1, 0, 0, 0);
        step("late_fl", 0, 1, 1, 0, 1, 0,  0,  1, 0, 1, 0, 0);

        // Spurious response sets a sticky error; clear restores reset state.
        step("err_set",  0, 0, 0, 1, 1, 0,  0,  1, 0, 0, 0, 1);
        step("err_hold", 0, 0, 0, 0, 1, 0,  0,  1, 0, 0, 0, 1);
        step("err_clr",  0, 0, 0, 0, 1, 1,  0,  0, 0, 0, 0, 0);

        // Only vector requesting: drain next cycle, select flips the cycle after.
        step("vo_d",  0, 1, 0, 0, 1, 0,  0,  0, 1, 0, 0, 0);
        step("vo_s",  0, 1, 0, 0, 1, 0,  0,  1, 0, 1, 0, 0);
        step("vo_b0", 0, 1, 1, 0, 1, 0,  1,  1, 0, 0, 1, 0);
        step("vo_b1", 0, 1, 1, 0, 1, 0,  1,  1, 0, 0, 2, 0);
        step("vo_dr", 1, 0, 1, 0, 1, 0,  0,  1, 1, 0, 2, 0);
        step("vo_clr", 0, 0, 0, 0, 1, 1,  0,  0, 0, 0, 0, 0);

        // burst_len 0 behaves as a single-beat burst.
        burst_len = 8'd0;
        step("bl0_a", 1, 1, 1, 0, 1, 0,  1,  0, 1, 0, 1, 0);
        step("bl0_b", 1, 1, 1, 1, 1, 0,  0,  0, 1, 0, 0, 0);
        step("bl0_c", 1, 1, 1, 0, 1, 0,  0,  1, 0, 1, 0, 0);
        step("bl0_d", 1, 1, 1, 0, 1, 0,  1,  1, 1, 0, 1, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
